pcb_bufid_recycle_ctrl: RTL and testbench

Buffer-ID lifecycle controller for the packet centralized buffer. After reset it seeds the free-buffer-ID FIFO with every buffer ID and clears a per-buffer reference-count table. It then holds the multicast use count written by the forward lookup table and round-robin arbitrates buffer-ID releases from the five output ports. A buffer ID goes back to the free FIFO only when its last user releases it.

---
 rtl/pcb_bufid_recycle_ctrl_if.sv | 28 ++
 rtl/pcb_bufid_recycle_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_pcb_bufid_recycle_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pcb_bufid_recycle_ctrl_if.sv
// Buffer-ID recycle bus: FLT use-count writes, per-port release handshake
// and the free-buffer-ID FIFO push/pop/full signals.
interface pcb_bufid_recycle_ctrl_if;
  logic        i_pkt_bufid_wr_flt;
  logic [8:0]  iv_pkt_bufid_flt;
  logic [3:0]  iv_pkt_bufid_cnt_flt;
  logic [44:0] iv_rel_bufid;
  logic [4:0]  iv_rel_req;
  logic [4:0]  ov_rel_ack;
  logic        o_free_bufid_wr;
  logic [8:0]  ov_free_bufid;
  logic        i_free_fifo_full;
  logic        i_free_bufid_rd;

  // Environment side: FLT, releasing ports and the free FIFO.
  modport master (
    output i_pkt_bufid_wr_flt, iv_pkt_bufid_flt, iv_pkt_bufid_cnt_flt,
    output iv_rel_bufid, iv_rel_req, i_free_fifo_full, i_free_bufid_rd,
    input  ov_rel_ack, o_free_bufid_wr, ov_free_bufid
  );

  // Recycle controller side.
  modport slave (
    input  i_pkt_bufid_wr_flt, iv_pkt_bufid_flt, iv_pkt_bufid_cnt_flt,
    input  iv_rel_bufid, iv_rel_req, i_free_fifo_full, i_free_bufid_rd,
    output ov_rel_ack, o_free_bufid_wr, ov_free_bufid
  );
endinterface

// File: rtl/pcb_bufid_recycle_ctrl.sv
// Buffer-ID lifecycle controller: seeds the free FIFO after reset, keeps a
// per-buffer multicast reference count and returns an ID to the free FIFO
// when its last user releases it.
module pcb_bufid_recycle_ctrl #(
  parameter int unsigned NUM_BUF = 512,
  parameter int unsigned LOW_WM  = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  pcb_bufid_recycle_ctrl_if.slave bus,
  output logic [9:0]              ov_free_cnt,
  output logic                    o_low_free_alarm,
  output logic                    o_init_done,
  output logic                    o_refcnt_err,
  output logic [3:0]              ov_recycle_state
);

  localparam logic [9:0] NUM_BUF_C = 10'(NUM_BUF);
  localparam logic [9:0] LOW_WM_C  = 10'(LOW_WM);

  typedef enum logic [2:0] {
    INIT_S = 3'd0,
    IDLE_S = 3'd1,
    RD_S   = 3'd2,
    UPD_S  = 3'd3,
    PUSH_S = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [9:0]  init_cnt, init_cnt_nx;
  logic [2:0]  last_grant, last_grant_nx;
  logic [8:0]  lat_id, lat_id_nx;
  logic [4:0]  ack_nx;
  logic        push_nx;
  logic [8:0]  push_id_nx;
  logic        err_nx;
  logic        init_done_nx;

  logic        gnt_found;
  logic [2:0]  gnt_idx;

  logic        flt_we;
  logic        b_we;
  logic [8:0]  b_addr;
  logic [3:0]  b_wdata;
  logic [3:0]  rd_data;
  logic [3:0]  ref_tbl [NUM_BUF];

  function automatic logic [2:0] rr_next(input logic [2:0] p);
    return (p >= 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  // Round-robin pick among requesting ports, starting after last_grant.
  always_comb begin
    logic [2:0] c;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    c         = rr_next(last_grant);
    for (int unsigned j = 0; j < 5; j++) begin
      if (!gnt_found && bus.iv_rel_req[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = c;
      end
      c = rr_next(c);
    end
  end

  // Next-state, table port-B control and next values of registered outputs.
  // The push strobe is decided one cycle ahead so it leaves a flop; in PUSH_S
  // a high strobe means the push is on the wire this cycle.
  always_comb begin
    state_nx      = state;
    init_cnt_nx   = init_cnt;
    last_grant_nx = last_grant;
    lat_id_nx     = lat_id;
    ack_nx        = '0;
    push_nx       = 1'b0;
    push_id_nx    = bus.ov_free_bufid;
    err_nx        = o_refcnt_err;
    init_done_nx  = o_init_done;
    b_we          = 1'b0;
    b_addr        = lat_id;
    b_wdata       = '0;
    unique case (state)
      INIT_S: begin
        if (init_cnt == NUM_BUF_C) begin
          state_nx     = IDLE_S;
          init_done_nx = 1'b1;
        end else if (!bus.i_free_fifo_full) begin
          push_nx     = 1'b1;
          push_id_nx  = init_cnt[8:0];
          b_we        = 1'b1;
          b_addr      = init_cnt[8:0];
          b_wdata     = '0;
          init_cnt_nx = init_cnt + 10'd1;
        end
      end
      IDLE_S: begin
        if (gnt_found) begin
          last_grant_nx = gnt_idx;
          lat_id_nx     = bus.iv_rel_bufid[gnt_idx*9 +: 9];
          ack_nx        = 5'b00001 << gnt_idx;
          state_nx      = RD_S;
        end
      end
      RD_S: begin
        state_nx = UPD_S;
      end
      UPD_S: begin
        if (rd_data == 4'd0) begin
          err_nx   = 1'b1;
          state_nx = IDLE_S;
        end else begin
          b_we    = 1'b1;
          b_wdata = rd_data - 4'd1;
          if (rd_data == 4'd1) begin
            state_nx = PUSH_S;
            if (!bus.i_free_fifo_full) begin
              push_nx    = 1'b1;
              push_id_nx = lat_id;
            end
          end else begin
            state_nx = IDLE_S;
          end
        end
      end
      PUSH_S: begin
        if (bus.o_free_bufid_wr) begin
          state_nx = IDLE_S;
        end else if (!bus.i_free_fifo_full) begin
          push_nx    = 1'b1;
          push_id_nx = lat_id;
        end
      end
      default: state_nx = INIT_S;
    endcase
  end

  // FSM state and registered handshake/status outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state               <= INIT_S;
      init_cnt            <= '0;
      last_grant          <= 3'd4;
      lat_id              <= '0;
      bus.ov_rel_ack      <= '0;
      bus.o_free_bufid_wr <= 1'b0;
      bus.ov_free_bufid   <= '0;
      o_refcnt_err        <= 1'b0;
      o_init_done         <= 1'b0;
    end else begin
      state               <= state_nx;
      init_cnt            <= init_cnt_nx;
      last_grant          <= last_grant_nx;
      lat_id              <= lat_id_nx;
      bus.ov_rel_ack      <= ack_nx;
      bus.o_free_bufid_wr <= push_nx;
      bus.ov_free_bufid   <= push_id_nx;
      o_refcnt_err        <= err_nx;
      o_init_done         <= init_done_nx;
    end
  end

  assign flt_we = bus.i_pkt_bufid_wr_flt && (state != INIT_S);

  // Reference table writes: FLT on port A wins over a same-address port-B write.
  always_ff @(posedge clk_sys) begin
    if (flt_we) begin
      ref_tbl[bus.iv_pkt_bufid_flt] <= bus.iv_pkt_bufid_cnt_flt;
    end
    if (b_we && !(flt_we && (bus.iv_pkt_bufid_flt == b_addr))) begin
      ref_tbl[b_addr] <= b_wdata;
    end
  end

  // Port-B read of the latched ID; data is consumed in UPD_S.
  always_ff @(posedge clk_sys) begin
    rd_data <= ref_tbl[lat_id];
  end

  // Free-ID count: pushes on the wire add, allocator pops subtract, saturating.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ov_free_cnt <= '0;
    end else if (bus.o_free_bufid_wr && !bus.i_free_bufid_rd) begin
      if (ov_free_cnt != NUM_BUF_C) ov_free_cnt <= ov_free_cnt + 10'd1;
    end else if (bus.i_free_bufid_rd && !bus.o_free_bufid_wr) begin
      if (ov_free_cnt != '0) ov_free_cnt <= ov_free_cnt - 10'd1;
    end
  end

  // Low-free alarm, suppressed until seeding has finished.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      o_low_free_alarm <= 1'b0;
    end else begin
      o_low_free_alarm <= o_init_done && (ov_free_cnt < LOW_WM_C);
    end
  end

  assign ov_recycle_state = {1'b0, state};

endmodule

// File: tb/tb_pcb_bufid_recycle_ctrl.sv
// Scoreboard bench for pcb_bufid_recycle_ctrl: expected pushes and acks are
// queued by the stimulus, a negedge monitor pops and compares them.
module tb_pcb_bufid_recycle_ctrl;
  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] free_cnt;
  logic       low_alarm, init_done, refcnt_err;
  logic [3:0] rstate;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned exp_push[$];
  int unsigned exp_ack[$];

  pcb_bufid_recycle_ctrl_if bus();

  pcb_bufid_recycle_ctrl #(.NUM_BUF(512), .LOW_WM(16)) dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .bus              (bus),
    .ov_free_cnt      (free_cnt),
    .o_low_free_alarm (low_alarm),
    .o_init_done      (init_done),
    .o_refcnt_err     (refcnt_err),
    .ov_recycle_state (rstate)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every push and every ack must match the head of its queue.
  always @(negedge clk_sys) begin
    if (bus.o_free_bufid_wr === 1'b1) begin
      if (exp_push.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL push_unexpected: got id %0d required no push", bus.ov_free_bufid);
      end else begin
        chk("push_id", 32'(bus.ov_free_bufid), exp_push.pop_front());
      end
    end
    if (bus.ov_rel_ack !== 5'b0) begin
      if (exp_ack.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ack_unexpected: got %b required none", bus.ov_rel_ack);
      end else begin
        chk("ack_onehot", 32'(bus.ov_rel_ack), 32'(5'b00001 << exp_ack.pop_front()));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic flt(input logic [8:0] id, input logic [3:0] cnt);
    @(negedge clk_sys);
    bus.i_pkt_bufid_wr_flt   = 1'b1;
    bus.iv_pkt_bufid_flt     = id;
    bus.iv_pkt_bufid_cnt_flt = cnt;
    @(negedge clk_sys);
    bus.i_pkt_bufid_wr_flt   = 1'b0;
  endtask

  // Raise requests for all ports in mask; drop each at its ack. Returns on
  // the negedge where the last ack is visible.
  task automatic rel_multi(input logic [4:0] mask, input logic [44:0] ids);
    int unsigned budget;
    bus.iv_rel_bufid = ids;
    bus.iv_rel_req   = mask;
    budget = 0;
    while (bus.iv_rel_req != 5'b0 && budget < 60) begin
      @(negedge clk_sys);
      bus.iv_rel_req = bus.iv_rel_req & ~bus.ov_rel_ack;
      budget++;
    end
    if (bus.iv_rel_req != 5'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rel_timeout: got pending %b required 00000", bus.iv_rel_req);
      bus.iv_rel_req = '0;
    end
  endtask

  task automatic rel1(input int unsigned port, input logic [8:0] id);
    logic [44:0] v;
    v = '0;
    v[port*9 +: 9] = id;
    exp_ack.push_back(port);
    rel_multi(5'(1) << port, v);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, 32'(bus.ov_rel_ack), 0);
    chk({tag, "_wr"}, 32'(bus.o_free_bufid_wr), 0);
    chk({tag, "_free_id"}, 32'(bus.ov_free_bufid), 0);
    chk({tag, "_free_cnt"}, 32'(free_cnt), 0);
    chk({tag, "_alarm"}, 32'(low_alarm), 0);
    chk({tag, "_init_done"}, 32'(init_done), 0);
    chk({tag, "_err"}, 32'(refcnt_err), 0);
    chk({tag, "_state"}, 32'(rstate), 0);
  endtask

  initial begin
    bus.i_pkt_bufid_wr_flt   = 1'b0;
    bus.iv_pkt_bufid_flt     = '0;
    bus.iv_pkt_bufid_cnt_flt = '0;
    bus.iv_rel_bufid         = '0;
    bus.iv_rel_req           = '0;
    bus.i_free_fifo_full     = 1'b0;
    bus.i_free_bufid_rd      = 1'b0;

    // Reset values, then plain seeding with the FIFO never full.
    repeat (3) @(negedge clk_sys);
    chk_reset_vals("rst");
    for (int unsigned i = 0; i < 512; i++) exp_push.push_back(i);
    reset_n = 1'b1;
    repeat (512) @(negedge clk_sys);
    chk("init_done_c512", 32'(init_done), 0);
    chk("free_cnt_c512", 32'(free_cnt), 511);
    @(negedge clk_sys);
    chk("init_done_c513", 32'(init_done), 1);
    chk("free_cnt_c513", 32'(free_cnt), 512);
    chk("state_idle", 32'(rstate), 1);
    chk("init_q_drained", exp_push.size(), 0);

    // All five ports at once on count-1 entries: round-robin from port 0.
    for (int unsigned p = 0; p < 5; p++) flt(9'(20 + p), 4'd1);
    begin
      logic [44:0] v;
      v = '0;
      for (int unsigned p = 0; p < 5; p++) begin
        v[p*9 +: 9] = 9'(20 + p);
        exp_ack.push_back(p);
        exp_push.push_back(20 + p);
      end
      rel_multi(5'b11111, v);
    end
    repeat (6) @(negedge clk_sys);
    chk("multi_push_drained", exp_push.size(), 0);
    chk("multi_ack_drained", exp_ack.size(), 0);
    chk("free_cnt_sat", 32'(free_cnt), 512);

    // Multicast ID 7 used by three ports: only the last release frees it.
    flt(9'd7, 4'd3);
    rel1(0, 9'd7);
    repeat (5) @(negedge clk_sys);
    rel1(2, 9'd7);
    repeat (5) @(negedge clk_sys);
    exp_push.push_back(7);
    rel1(4, 9'd7);
    repeat (6) @(negedge clk_sys);
    chk("mc7_push_drained", exp_push.size(), 0);
    chk("err_before", 32'(refcnt_err), 0);

    // Entry 7 is now 0: releasing it again flags the error, no push.
    rel1(1, 9'd7);
    repeat (4) @(negedge clk_sys);
    chk("refcnt_err_set", 32'(refcnt_err), 1);
    chk("state_after_err", 32'(rstate), 1);

    // Error is sticky across a normal release.
    flt(9'd30, 4'd1);
    exp_push.push_back(30);
    rel1(3, 9'd30);
    repeat (5) @(negedge clk_sys);
    chk("refcnt_err_sticky", 32'(refcnt_err), 1);
    chk("id30_push_drained", exp_push.size(), 0);

    // Allocator pops 500 IDs.
    bus.i_free_bufid_rd = 1'b1;
    repeat (500) @(negedge clk_sys);
    bus.i_free_bufid_rd = 1'b0;
    chk("free_cnt_12", 32'(free_cnt), 12);
    @(negedge clk_sys);
    chk("low_alarm", 32'(low_alarm), 1);

    // Push and pop in the same cycle leave the count alone.
    flt(9'd40, 4'd1);
    exp_push.push_back(40);
    rel1(2, 9'd40);
    repeat (2) @(negedge clk_sys);
    bus.i_free_bufid_rd = 1'b1;
    @(negedge clk_sys);
    bus.i_free_bufid_rd = 1'b0;
    chk("push_pop_cnt", 32'(free_cnt), 12);
    repeat (3) @(negedge clk_sys);
    chk("id40_push_drained", exp_push.size(), 0);
    chk("low_alarm_hold", 32'(low_alarm), 1);

    // Reset while UPD_S is handling ID 50: its push must never appear.
    flt(9'd50, 4'd1);
    rel1(0, 9'd50);
    @(negedge clk_sys);
    chk("state_upd", 32'(rstate), 3);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk_sys);

    // Re-seed with a 10-cycle FIFO-full stall at ID 100.
    for (int unsigned i = 0; i < 512; i++) exp_push.push_back(i);
    reset_n = 1'b1;
    repeat (100) @(negedge clk_sys);
    bus.i_free_fifo_full = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk_sys);
      chk("stall_no_push", 32'(bus.o_free_bufid_wr), 0);
    end
    bus.i_free_fifo_full = 1'b0;
    repeat (412) @(negedge clk_sys);
    chk("stall_init_done_c522", 32'(init_done), 0);
    @(negedge clk_sys);
    chk("stall_init_done_c523", 32'(init_done), 1);
    chk("stall_free_cnt", 32'(free_cnt), 512);
    chk("stall_q_drained", exp_push.size(), 0);

    // Table was recleared: ID 50 now has count 0.
    rel1(0, 9'd50);
    repeat (4) @(negedge clk_sys);
    chk("recleared_err", 32'(refcnt_err), 1);

    repeat (10) @(negedge clk_sys);
    chk("final_push_q", exp_push.size(), 0);
    chk("final_ack_q", exp_ack.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
